// File: rtl/alu_seq_exec.sv
// alu_seq_exec: EX-stage execute unit with single-cycle ALU ops
// and an iterative signed shift-add multiplier writing hi/lo.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH-1:0]   alu_res;
    logic [2*WIDTH-1:0] add_sum;
    logic [2*WIDTH-1:0] prod;

    // Unsigned magnitudes; the most-negative value maps to 2^(W-1).
    assign abs1 = src1_i[WIDTH-1] ? -src1_i : src1_i;
    assign abs2 = src2_i[WIDTH-1] ? -src2_i : src2_i;

    // Single-cycle operation result for the non-multiply codes.
    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(src1_i) < $signed(src2_i)};
            default: alu_res = '0;
        endcase
    end

    // Control FSM and shift-add datapath next-state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        add_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod     = sign_q ? -add_sum : add_sum;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (ctrl_i == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, abs1};
                        mplier_d = abs2;
                        sign_d   = src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = add_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_IDLE;
                    result_d = prod[WIDTH-1:0];
                    hi_d     = prod[2*WIDTH-1:WIDTH];
                    zero_d   = (prod[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any partial product.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign hi_o     = hi_q;
    assign zero_o   = zero_q;
    assign busy_o   = (state_q == S_MUL);
    assign done_o   = done_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed and random checks of alu_seq_exec
// against an arithmetic reference model.
module tb_alu_seq_exec;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   ctrl;
    logic [W-1:0] src1, src2;
    logic [W-1:0] result, hi;
    logic         zero, busy, done;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_hi = '0;

    alu_seq_exec #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .ctrl_i   (ctrl),
        .src1_i   (src1),
        .src2_i   (src2),
        .result_o (result),
        .hi_o     (hi),
        .zero_o   (zero),
        .busy_o   (busy),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] c,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (c == 4'd0) return a & b;
        if (c == 4'd1) return a | b;
        if (c == 4'd2) return W'(sa + sb);
        if (c == 4'd6) return W'(sa - sb);
        if (c == 4'd7) return (sa < sb) ? W'(1) : W'(0);
        return '0;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint pa, pb;
        pa = longint'(int'(a));
        pb = longint'(int'(b));
        return 64'(pa * pb);
    endfunction

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        ctrl  = c;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_alu(input logic [3:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        logic [W-1:0] e;
        issue(c, a, b);
        e = ref_alu(c, a, b);
        check("alu_res", 64'(result), 64'(e));
        check("alu_zero", 64'(zero), 64'(e == '0));
        check("alu_done", 64'(done), 64'(1));
        check("alu_hi", 64'(hi), 64'(exp_hi));
        check("alu_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check("alu_done_drop", 64'(done), 64'(0));
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int ign);
        logic [W-1:0] r0;
        logic [63:0]  p;
        r0 = result;
        issue(4'd3, a, b);
        check("mul_busy_e0", 64'(busy), 64'(1));
        p = ref_mul(a, b);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            src1 = $urandom;
            src2 = $urandom;
            ctrl = 4'($urandom);
            if (k == ign) begin
                start = 1'b1;
                ctrl  = 4'd2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k < W) begin
                check("mul_busy", 64'(busy), 64'(1));
                check("mul_nodone", 64'(done), 64'(0));
                check("mul_hold", 64'(result), 64'(r0));
            end
        end
        exp_hi = p[63:32];
        check("mul_lo", 64'(result), 64'(p[31:0]));
        check("mul_hi", 64'(hi), 64'(p[63:32]));
        check("mul_zero", 64'(zero), 64'(p[31:0] == '0));
        check("mul_done", 64'(done), 64'(1));
        check("mul_idle", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check("mul_done_drop", 64'(done), 64'(0));
    endtask

    initial begin
        logic [3:0] codes [6];
        logic [3:0] c;
        logic [W-1:0] a, b;
        int ndone;
        codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3};
        rst   = 1'b0;
        start = 1'b0;
        ctrl  = '0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res", 64'(result), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_zero", 64'(zero), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // back-to-back ADD then SUB
        issue(4'd2, 32'd5, 32'd7);
        check("add_res", 64'(result), 64'd12);
        check("add_zero", 64'(zero), 64'(0));
        check("add_done", 64'(done), 64'(1));
        start = 1'b1;
        ctrl  = 4'd6;
        src1  = 32'd3;
        src2  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("sub_res", 64'(result), 64'hFFFF_FFFE);
        check("sub_done_held", 64'(done), 64'(1));
        @(posedge clk);
        #1;
        check("sub_done_drop", 64'(done), 64'(0));

        run_alu(4'd7, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg", 64'(result), 64'd1);
        run_alu(4'd7, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos", 64'(result), 64'd0);
        run_alu(4'd0, 32'hF0F0, 32'h0FF0);
        check("and", 64'(result), 64'h00F0);
        run_alu(4'd1, 32'hF0F0, 32'h0FF0);
        check("or", 64'(result), 64'hFFF0);
        run_alu(4'hF, 32'h1234, 32'h5678);
        check("bad_code", 64'(result), 64'd0);

        run_mul(-32'sd3, 32'd7, 10);
        check("m37_hi", 64'(hi), 64'hFFFF_FFFF);
        check("m37_lo", 64'(result), 64'hFFFF_FFEB);
        run_mul(32'h8000_0000, 32'h8000_0000, -1);
        check("mneg_hi", 64'(hi), 64'h4000_0000);
        run_mul(32'd0, 32'h1234_5678, -1);
        check("m0_zero", 64'(zero), 64'(1));
        run_alu(4'd2, 32'd1, 32'd1);
        check("add_keeps_hi", 64'(hi), 64'd0);
        run_mul(32'h7FFF_FFFF, 32'h8000_0000, -1);
        run_alu(4'd2, 32'd1, 32'd1);

        // reset in the middle of a multiply
        issue(4'd3, 32'd1234, 32'd5678);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_hi = '0;
        check("mrst_res", 64'(result), 64'(0));
        check("mrst_hi", 64'(hi), 64'(0));
        check("mrst_zero", 64'(zero), 64'(1));
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("mrst_no_done", 64'(ndone), 64'(0));
        run_mul(32'd6, 32'd7, -1);
        check("m67_lo", 64'(result), 64'd42);
        check("m67_hi", 64'(hi), 64'd0);

        // random operations
        for (int i = 0; i < 60; i++) begin
            c = ($urandom_range(0, 6) == 6) ? 4'($urandom)
                                             : codes[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 4) == 0) b = $urandom_range(0, 3);
            if ($urandom_range(0, 6) == 0) b = a;
            if (c == 4'd3)
                run_mul(a, b, int'($urandom_range(1, W)));
            else
                run_alu(c, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
